// File: rtl/n_count_pkg.sv
// Shared constants and elaboration helpers for the n_count slow-phase generator.
package n_count_pkg;

    localparam int unsigned MSB_W = 2;

    // The counter must be at least as wide as the exposed MSB slice.
    function automatic bit width_ok(input int n);
        return n >= int'(MSB_W);
    endfunction

endpackage

// File: rtl/n_count_reg.sv
// Generic width-parameterised up-counter with synchronous active-low reset.
module n_count_reg #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Reset has priority; wrap from all-ones to zero is natural modulo arithmetic.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/n_count.sv
// Free-running N-bit counter exposing only its two MSBs as a slow phase output.
module n_count
    import n_count_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [MSB_W-1:0] msbs
);

    generate
        if (!width_ok(N)) begin : g_bad_width
            $error("n_count: N must be >= 2");
        end
    endgenerate

    logic [N-1:0] w_count;
    logic         w_unused_low;

    n_count_reg #(
        .W(N)
    ) u_reg (
        .i_clk  (clk),
        .i_rst_n(rst),
        .o_count(w_count)
    );

    assign msbs = w_count[N-1:N-2];

    // Low counter bits only feed the carry chain, never the output.
    assign w_unused_low = ^w_count;

endmodule

// File: tb/tb_n_count.sv
// Scoreboard bench for n_count at N=2, N=3 and N=6 sharing one clock and reset.
module tb_n_count;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] msbs2;
    logic [1:0] msbs3;
    logic [1:0] msbs6;

    always #5 clk = ~clk;

    n_count #(.N(2)) u_n2 (.clk(clk), .rst(rst), .msbs(msbs2));
    n_count #(.N(3)) u_n3 (.clk(clk), .rst(rst), .msbs(msbs3));
    n_count #(.N(6)) u_n6 (.clk(clk), .rst(rst), .msbs(msbs6));

    typedef struct {
        logic [1:0] m2;
        logic [1:0] m3;
        logic [2:0] c3;
        logic [1:0] m6;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   c2          = 0;
    int   c6          = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: counter output is valid every cycle, so pop one entry per edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            check("msbs_n2",  {6'd0, msbs2}, {6'd0, e.m2});
            check("msbs_n3",  {6'd0, msbs3}, {6'd0, e.m3});
            check("count_n3", {5'd0, u_n3.u_reg.r_count}, {5'd0, e.c3});
            check("msbs_n6",  {6'd0, msbs6}, {6'd0, e.m6});
        end
    end

    // exp3 is the hand-computed N=3 count after the coming edge; N=2/N=6 use a simple model.
    task automatic step(input logic r, input int exp3, input bit glitch = 1'b0);
        exp_t e;
        @(negedge clk);
        rst = r;
        if (glitch) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
        end
        c2 = r ? (c2 + 1) % 4  : 0;
        c6 = r ? (c6 + 1) % 64 : 0;
        e.m2 = c2[1:0];
        e.m3 = exp3[2:1];
        e.c3 = exp3[2:0];
        e.m6 = c6[5:4];
        sb.push_back(e);
    endtask

    int release_seq[13] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5};

    initial begin
        int e3;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset from unknown state, then release and run through a wrap to count 5.
        step(1'b0, 0);
        foreach (release_seq[i]) step(1'b1, release_seq[i]);

        // Single-cycle reset mid-count.
        step(1'b0, 0);
        step(1'b1, 1);

        // Reset held for five edges.
        repeat (5) step(1'b0, 0);
        step(1'b1, 1);
        step(1'b1, 2);

        // A reset pulse between edges must be ignored.
        step(1'b1, 3, 1'b1);
        step(1'b1, 4);

        // Long run covering a full N=6 period and several N=3 wraps.
        e3 = 4;
        for (int i = 0; i < 72; i++) begin
            e3 = (e3 + 1) % 8;
            step(1'b1, e3);
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
